// File: rtl/keypad_fifo_deco.sv
// Keypad scan-code decoder with a first-word-fall-through key FIFO.
// Define KEYPAD_FIFO_OVF_CNT_EN to add the saturating ovf_count output.
module keypad_fifo_deco #(
  parameter int NCOLS = 4,
  parameter int NROWS = 4,
  parameter int DEPTH = 4,
  localparam int KW = $clog2(NCOLS * NROWS),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                   clk_27mhz,
  input  logic                   reset_n,
  input  logic                   key_valid,
  input  logic [NCOLS+NROWS-1:0] key_code_raw,
  input  logic                   mode_hex,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [KW-1:0]          out_value,
  output logic [LW-1:0]          fill_level,
  output logic                   err_invalid,
  output logic                   overflow
`ifdef KEYPAD_FIFO_OVF_CNT_EN
  , output logic [7:0]           ovf_count
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [NCOLS+NROWS-1:0] hold_code;
  logic                   hold_hex;
  logic                   pending;

  logic [KW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;

  logic [NCOLS-1:0] col_n;
  logic [NROWS-1:0] row_n;
  logic [3:0]       col_cnt;
  logic [3:0]       row_cnt;
  logic [2:0]       col_idx;
  logic [2:0]       row_idx;
  logic             code_ok;
  logic [KW-1:0]    dec_value;

  logic full;
  logic pop;
  logic push;
  logic ovf_cond;

  function automatic logic [3:0] hex_map(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] v;
    case ({col, row})
      4'h0: v = 4'h1;  4'h1: v = 4'h4;  4'h2: v = 4'h7;  4'h3: v = 4'hE;
      4'h4: v = 4'h2;  4'h5: v = 4'h5;  4'h6: v = 4'h8;  4'h7: v = 4'h0;
      4'h8: v = 4'h3;  4'h9: v = 4'h6;  4'hA: v = 4'h9;  4'hB: v = 4'hF;
      4'hC: v = 4'hA;  4'hD: v = 4'hB;  4'hE: v = 4'hC;  default: v = 4'hD;
    endcase
    return v;
  endfunction

  // Active-low code: a legal press pulls exactly one column and one row low.
  always_comb begin
    col_n   = hold_code[NCOLS+NROWS-1:NROWS];
    row_n   = hold_code[NROWS-1:0];
    col_cnt = '0;
    row_cnt = '0;
    col_idx = '0;
    row_idx = '0;
    for (int c = 0; c < NCOLS; c++) begin
      if (!col_n[c]) begin
        col_cnt = col_cnt + 4'd1;
        col_idx = 3'(c);
      end
    end
    for (int r = 0; r < NROWS; r++) begin
      if (!row_n[r]) begin
        row_cnt = row_cnt + 4'd1;
        row_idx = 3'(r);
      end
    end
    code_ok = (col_cnt == 4'd1) && (row_cnt == 4'd1);
    if (NCOLS == 4 && NROWS == 4 && hold_hex)
      dec_value = KW'(hex_map(col_idx[1:0], row_idx[1:0]));
    else
      dec_value = KW'(int'(col_idx) * NROWS + int'(row_idx));
  end

  assign out_valid  = (count != '0);
  assign full       = (count == LW'(DEPTH));
  assign pop        = out_valid & out_ready & ~flush;
  assign push       = pending & code_ok & ~flush & (~full | pop);
  assign ovf_cond   = pending & code_ok & ~flush & full & ~pop;
  assign out_value  = out_valid ? mem[rd_ptr] : '0;
  assign fill_level = count;

  always_ff @(posedge clk_27mhz) begin
    if (push) mem[wr_ptr] <= dec_value;
  end

  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      hold_code   <= '1;
      hold_hex    <= 1'b0;
      pending     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_invalid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      pending <= key_valid & ~flush;
      if (key_valid) begin
        hold_code <= key_code_raw;
        hold_hex  <= mode_hex;
      end
      err_invalid <= pending & ~code_ok & ~flush;
      overflow    <= ovf_cond;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + LW'(1);
        else if (pop && !push) count <= count - LW'(1);
      end
    end
  end

`ifdef KEYPAD_FIFO_OVF_CNT_EN
  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n)                         ovf_count <= 8'd0;
    else if (flush)                       ovf_count <= 8'd0;
    else if (ovf_cond && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end
`endif

endmodule

// File: doc/keypad_fifo_deco.md
KEYPAD_FIFO_DECO -- requirements
Module: keypad_fifo_deco

Interface
REQ-001 Parameter NCOLS, default 4, keypad column count; legal range 2..8.
REQ-002 Parameter NROWS, default 4, keypad row count; legal range 2..8.
REQ-003 Parameter DEPTH, default 4, key FIFO entries; power of two, 2..16.
REQ-004 Derived widths SHALL be KW = $clog2(NCOLS*NROWS) and LW = $clog2(DEPTH+1).
REQ-005 Port clk_27mhz  input  1  system clock; all logic is on its rising edge.
REQ-006 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 Port key_valid  input  1  single-cycle strobe qualifying key_code_raw.
REQ-008 Port key_code_raw  input  NCOLS+NROWS  active-low code: bits [NCOLS+NROWS-1:NROWS] are columns (bit NROWS is col 0), bits [NROWS-1:0] are rows (bit 0 is row 0).
REQ-009 Port mode_hex  input  1  1 selects the hex keypad map; honoured only when NCOLS=4 and NROWS=4.
REQ-010 Port flush  input  1  synchronous FIFO clear.
REQ-011 Port out_valid  output  1  FIFO not empty.
REQ-012 Port out_ready  input  1  consumer accepts the head entry.
REQ-013 Port out_value  output  KW  decoded key value at the FIFO head.
REQ-014 Port fill_level  output  LW  number of stored entries.
REQ-015 Port err_invalid  output  1  one-cycle pulse: the strobed code was not a single key.
REQ-016 Port overflow  output  1  one-cycle pulse: a valid key was dropped because the FIFO was full.

Function
REQ-017 Stage 1: on an edge with key_valid=1, the block SHALL capture key_code_raw and mode_hex into a holding register and set a pending flag; the pending flag SHALL clear on the next edge unless key_valid is 1 again.
REQ-018 A code is valid only if exactly one column bit and exactly one row bit are 0.
REQ-019 Linear map: value = col*NROWS + row.
REQ-020 Hex map (4x4 with mode_hex=1): col0 rows0-3 = 1,4,7,E; col1 = 2,5,8,0; col2 = 3,6,9,F; col3 = A,B,C,D.
REQ-021 Stage 2: on the edge after capture, a valid code SHALL be written to the FIFO tail; out_valid SHALL be high after that edge, giving 2-edge latency from the key_valid sample.
REQ-022 An invalid code SHALL NOT be written, and err_invalid SHALL pulse high for the one cycle following the stage-2 edge.
REQ-023 FIFO is first-word-fall-through: out_value SHALL always show the head entry while out_valid=1.
REQ-024 An entry pops on an edge where out_valid=1 and out_ready=1.
REQ-025 When full with no simultaneous pop, a valid write SHALL be dropped, FIFO contents SHALL be unchanged, and overflow SHALL pulse for one cycle.
REQ-026 When full with a simultaneous pop, the write SHALL be accepted and fill_level SHALL stay at DEPTH.
REQ-027 On a simultaneous push and pop while empty, the push SHALL be accepted and the pop SHALL be ignored, because out_valid=0.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 fill_level SHALL equal pushes minus pops and SHALL never exceed DEPTH.
REQ-030 flush=1 SHALL empty the FIFO and discard the pending stage-1 entry on that edge.
REQ-031 flush SHALL take priority over push and pop, and SHALL cause no err_invalid or overflow pulse.
REQ-032 Back-to-back key_valid strobes on consecutive cycles SHALL each be processed, one FIFO write per cycle.

Reset
REQ-033 When reset_n=0, the block SHALL immediately force: FIFO empty, pointers 0, pending flag 0, holding register all-ones, out_valid 0, out_value 0, fill_level 0, err_invalid 0, overflow 0.
REQ-034 Reset asserted mid-operation SHALL discard all stored and pending keys.
REQ-035 After reset release, the first key_valid SHALL be processed normally.

Configuration
REQ-036 Macro KEYPAD_FIFO_OVF_CNT_EN, when defined, SHALL add output ovf_count (8 bits, reset 0).
REQ-037 ovf_count SHALL increment on each overflow pulse, saturate at 255, and clear on flush.
REQ-038 When KEYPAD_FIFO_OVF_CNT_EN is undefined, ovf_count and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 4x4, mode_hex=1, strobe 8'b1101_0111 -> out_value=4'h0 and out_valid=1 two edges later; fill_level=1.
REQ-040 4x4, mode_hex=0, strobe 8'b1011_1101 -> out_value=9 (col 2, row 1); strobe 8'b1100_1110 -> err_invalid pulse, no write.
REQ-041 DEPTH=4, out_ready=0, 5 valid strobes -> fill_level=4, one overflow pulse, pops return the first 4 keys in order.
REQ-042 Full FIFO with out_ready=1 and a valid strobe in the same cycle -> write accepted, fill_level stays 4, no overflow.
REQ-043 Strobe, then flush on the next edge -> FIFO empty and no write; reset_n low with 3 entries stored -> out_valid=0 and fill_level=0 immediately.
